// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; WIDTH iterations
// plus one sign-fix cycle. MTHI/MTLO write HI/LO directly from A when idle.
module hilo_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Abort,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivZero
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;      // mul: {partial, multiplier}; div: {rem, quot}
    logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;      // sA ^ sB
    logic               sa_q, sa_d;        // remainder takes the dividend sign
    logic               dz_q, dz_d;        // this divide has a zero divisor
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               divzero_q, divzero_d;

    // Iteration datapath shared by RUN
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // One shift-add step and one restoring-divide step, plus sign-corrected results
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        prod_fix  = neg_q ? -acc_q : acc_q;
        // Zero divisor: quotient is all ones unsigned, remainder reproduces raw A
        quot_fix  = dz_q ? {WIDTH{1'b1}}
                         : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        rem_fix   = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state and register updates for the IDLE/RUN/FIX sequencer
    always_comb begin
        logic is_signed;
        logic a_neg;
        logic b_neg;
        logic [WIDTH-1:0] a_mag;
        logic [WIDTH-1:0] b_mag;

        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        sa_d      = sa_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divzero_d = divzero_q;

        is_signed = ~Op[0];
        a_neg     = is_signed & A[WIDTH-1];
        b_neg     = is_signed & B[WIDTH-1];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    if (Op == 3'b100) begin
                        hi_d = A;
                    end else if (Op == 3'b101) begin
                        lo_d = A;
                    end else if (!Op[2]) begin
                        is_div_d = Op[1];
                        neg_d    = a_neg ^ b_neg;
                        sa_d     = a_neg;
                        dz_d     = Op[1] && (B == '0);
                        cnt_d    = '0;
                        state_d  = StRun;
                        if (Op[1]) begin
                            acc_d  = {{WIDTH{1'b0}}, a_mag};
                            opnd_d = b_mag;
                            if (B == '0) begin
                                divzero_d = 1'b1;
                            end
                        end else begin
                            acc_d  = {{WIDTH{1'b0}}, b_mag};
                            opnd_d = a_mag;
                        end
                    end
                end
            end
            StRun: begin
                if (Abort) begin
                    state_d = StIdle;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastIter) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!Abort) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            sa_q      <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            sa_q      <= sa_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign Busy    = (state_q != StIdle);
    assign Done    = done_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;
    assign DivZero = divzero_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus pushes expected {Hi,Lo},
// a monitor pops and compares on every Done pulse.
module tb_hilo_muldiv_unit;

    localparam int unsigned W = 32;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    logic         Clk;
    logic         Rst;
    logic         Start;
    logic [2:0]   Op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Abort;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;
    logic         DivZero;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*W-1:0] exp_q[$];

    hilo_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .Abort   (Abort),
        .Busy    (Busy),
        .Done    (Done),
        .Hi      (Hi),
        .Lo      (Lo),
        .DivZero (DivZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; request is held across exactly one rising edge
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    // Returns at the negedge where Done is seen; counts Busy cycles on the way
    task automatic wait_done(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (Done) return;
            if (Busy) busy_cycles++;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_done: timeout, Done never seen after 200 cycles");
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh,
                          input logic [W-1:0] el);
        int c;
        exp_q.push_back({eh, el});
        issue(op, a, b);
        wait_done(c);
        check({name, "_latency"}, 64'(c), 64'd33);
    endtask

    // Monitor: every Done pulse must match the oldest expected result
    always @(negedge Clk) begin
        if (Rst === 1'b1 && Done === 1'b1) begin
            check("busy_done_exclusive", {63'd0, Busy}, 64'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got Hi=0x%0h Lo=0x%0h expected no Done", Hi, Lo);
            end else begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                check("sb_hi", 64'(Hi), 64'(e[2*W-1:W]));
                check("sb_lo", 64'(Lo), 64'(e[W-1:0]));
            end
        end
    end

    initial begin
        int c;
        Rst   = 1'b0;
        Start = 1'b0;
        Op    = 3'b111;
        A     = '0;
        B     = '0;
        Abort = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_hi", 64'(Hi), 64'd0);
        check("rst_lo", 64'(Lo), 64'd0);
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_divzero", {63'd0, DivZero}, 64'd0);
        Rst = 1'b1;
        @(negedge Clk);

        run_op("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", OpMult, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_minmin", OpMult, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        run_op("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check("divzero_clear", {63'd0, DivZero}, 64'd0);
        run_op("divu", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14);
        check("divzero_still_clear", {63'd0, DivZero}, 64'd0);
        run_op("divu_zero", OpDivu, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF);
        check("divzero_set", {63'd0, DivZero}, 64'd1);
        run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("div_neg_zero", OpDiv, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        check("divzero_sticky", {63'd0, DivZero}, 64'd1);

        // MTHI then MTLO on consecutive edges
        Start = 1'b1;
        Op    = OpMthi;
        A     = 32'hAAAA_0000;
        @(posedge Clk);
        #1;
        check("mthi_hi", 64'(Hi), 64'hAAAA_0000);
        check("mthi_busy", {63'd0, Busy}, 64'd0);
        Op = OpMtlo;
        A  = 32'h0000_5555;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        check("mtlo_lo", 64'(Lo), 64'h5555);
        check("mtlo_hi_kept", 64'(Hi), 64'hAAAA_0000);
        check("mtlo_busy", {63'd0, Busy}, 64'd0);
        check("mtlo_done", {63'd0, Done}, 64'd0);
        @(negedge Clk);

        // Requests raised while Busy must be ignored
        exp_q.push_back({32'd0, 32'd15});
        issue(OpMultu, 32'd3, 32'd5);
        repeat (4) @(negedge Clk);
        Start = 1'b1;
        Op    = OpMthi;
        A     = 32'hDEAD_BEEF;
        repeat (3) @(negedge Clk);
        Op = OpMult;
        A  = 32'd9;
        B  = 32'd9;
        repeat (3) @(negedge Clk);
        Start = 1'b0;
        wait_done(c);
        check("busy_ignore_hi", 64'(Hi), 64'd0);
        check("busy_ignore_lo", 64'(Lo), 64'd15);

        // Abort in RUN cycle 10
        issue(OpMultu, 32'd7, 32'd9);
        repeat (10) @(negedge Clk);
        Abort = 1'b1;
        @(posedge Clk);
        #1;
        Abort = 1'b0;
        check("abort_run_busy", {63'd0, Busy}, 64'd0);
        repeat (40) @(negedge Clk);
        check("abort_run_hi", 64'(Hi), 64'd0);
        check("abort_run_lo", 64'(Lo), 64'd15);

        // Abort in the FIX cycle beats completion
        issue(OpMultu, 32'd7, 32'd9);
        repeat (33) @(negedge Clk);
        check("fix_busy", {63'd0, Busy}, 64'd1);
        Abort = 1'b1;
        @(posedge Clk);
        #1;
        Abort = 1'b0;
        check("abort_fix_busy", {63'd0, Busy}, 64'd0);
        check("abort_fix_done", {63'd0, Done}, 64'd0);
        check("abort_fix_lo", 64'(Lo), 64'd15);
        repeat (5) @(negedge Clk);

        // Back-to-back: next MULTU issued in the Done cycle
        exp_q.push_back({32'd0, 32'd42});
        issue(OpMultu, 32'd6, 32'd7);
        wait_done(c);
        exp_q.push_back({32'd0, 32'd6});
        issue(OpMultu, 32'd2, 32'd3);
        wait_done(c);
        check("b2b_latency", 64'(c), 64'd33);

        // Asynchronous reset mid-RUN
        issue(OpMultu, 32'd11, 32'd13);
        repeat (5) @(negedge Clk);
        #2;
        Rst = 1'b0;
        #1;
        check("arst_hi", 64'(Hi), 64'd0);
        check("arst_lo", 64'(Lo), 64'd0);
        check("arst_busy", {63'd0, Busy}, 64'd0);
        check("arst_divzero", {63'd0, DivZero}, 64'd0);
        @(negedge Clk);
        Rst = 1'b1;
        repeat (40) @(negedge Clk);
        check("arst_done", {63'd0, Done}, 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
